simplerisc_dmem_responder: RTL and testbench

Data-memory responder: the memory-side end of the processor's MA-stage load/store interface. It accepts one ld/st request at a time over a valid/ready handshake and models a configurable number of wait states. It returns a response (load data or store acknowledge) over a second valid/ready handshake. It holds the 1024-word data store and replaces the zero-latency array the processor indexes directly, so the pipeline can be tested against realistic memory timing.

---
 rtl/simplerisc_pkg.sv | 16 +
 rtl/simplerisc_dmem_array.sv | 32 +++
 rtl/simplerisc_dmem_responder.sv | 159 +++++++++++++++
 tb/tb_simplerisc_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC definitions: data-memory geometry, ld/st opcodes and responder FSM states.
package simplerisc_pkg;

    localparam int DMEM_DEPTH  = 1024;
    localparam int DMEM_ADDR_W = 10;

    localparam logic [4:0] OP_LD = 5'b01110;
    localparam logic [4:0] OP_ST = 5'b01111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/simplerisc_dmem_array.sv
// Single-port synchronous data store: write or read when en is high, read data valid the edge after.
module simplerisc_dmem_array
    import simplerisc_pkg::*;
#(
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk1,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // rdata_q only moves on a read, so it holds the last load result between accesses.
    always_ff @(posedge clk1) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/simplerisc_dmem_responder.sv
// Data-memory responder with valid/ready request/response and WAIT_STATES wait cycles.
// Optional DMEM_PERF_CNT_EN adds ld_count/st_count successful-access counters.
module simplerisc_dmem_responder
    import simplerisc_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEPTH,
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_st,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] ld_count,
    output logic [31:0] st_count
`endif
);

    localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        st_q, st_d;
    logic        err_q, err_d;
    logic        rd_sel_q, rd_sel_d;

    logic        acc;
    logic        in_range;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_st;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_rdata;

    // With zero wait states the access happens on the acceptance edge, so use the live request.
    assign a_addr   = (state_q == IDLE) ? req_addr  : addr_q;
    assign a_wdata  = (state_q == IDLE) ? req_wdata : wdata_q;
    assign a_st     = (state_q == IDLE) ? req_is_st : st_q;
    assign in_range = (a_addr >> ADDR_W) == 32'd0;
    assign ram_en   = acc && in_range;
    assign ram_we   = ram_en && a_st;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        st_d     = st_q;
        err_d    = err_q;
        rd_sel_d = rd_sel_q;
        acc      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    st_d    = req_is_st;
                    if (WAIT_STATES == 0) begin
                        acc     = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = WS_M1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc     = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (acc) begin
            err_d    = !in_range;
            rd_sel_d = in_range && !a_st;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            st_q     <= 1'b0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            st_q     <= st_d;
            err_q    <= err_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    simplerisc_dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk1  (clk1),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (a_addr[ADDR_W-1:0]),
        .wdata (a_wdata),
        .rdata (ram_rdata)
    );

    // Stores and errors report zero; the RAM output register holds load data until the next load.
    assign rsp_rdata = rd_sel_q ? ram_rdata : 32'd0;
    assign rsp_err   = err_q;
    assign rsp_valid = (state_q == RESP);
    assign req_ready = (state_q == IDLE);

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] ld_cnt_q, st_cnt_q;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            ld_cnt_q <= 32'd0;
            st_cnt_q <= 32'd0;
        end else if (ram_en) begin
            if (a_st) begin
                st_cnt_q <= st_cnt_q + 32'd1;
            end else begin
                ld_cnt_q <= ld_cnt_q + 32'd1;
            end
        end
    end

    assign ld_count = ld_cnt_q;
    assign st_count = st_cnt_q;
`endif

endmodule

// File: tb/tb_simplerisc_dmem_responder.sv
// Bench for simplerisc_dmem_responder: WAIT_STATES=0 and WAIT_STATES=2 instances, table vectors plus corner sequences.
module tb_simplerisc_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid [2];
    logic        req_is_st [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_ready [2];

    logic        req_ready_0, req_ready_2;
    logic        rsp_valid_0, rsp_valid_2;
    logic        rsp_err_0, rsp_err_2;
    logic [31:0] rsp_rdata_0, rsp_rdata_2;
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] ld_count_0, st_count_0, ld_count_2, st_count_2;
`endif

    simplerisc_dmem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk1      (clk),
        .rst       (rst),
        .req_valid (req_valid[0]),
        .req_ready (req_ready_0),
        .req_is_st (req_is_st[0]),
        .req_addr  (req_addr[0]),
        .req_wdata (req_wdata[0]),
        .rsp_valid (rsp_valid_0),
        .rsp_ready (rsp_ready[0]),
        .rsp_rdata (rsp_rdata_0),
        .rsp_err   (rsp_err_0)
`ifdef DMEM_PERF_CNT_EN
        ,
        .ld_count  (ld_count_0),
        .st_count  (st_count_0)
`endif
    );

    simplerisc_dmem_responder #(.WAIT_STATES(2)) u_ws2 (
        .clk1      (clk),
        .rst       (rst),
        .req_valid (req_valid[1]),
        .req_ready (req_ready_2),
        .req_is_st (req_is_st[1]),
        .req_addr  (req_addr[1]),
        .req_wdata (req_wdata[1]),
        .rsp_valid (rsp_valid_2),
        .rsp_ready (rsp_ready[1]),
        .rsp_rdata (rsp_rdata_2),
        .rsp_err   (rsp_err_2)
`ifdef DMEM_PERF_CNT_EN
        ,
        .ld_count  (ld_count_2),
        .st_count  (st_count_2)
`endif
    );

    typedef struct {
        logic        st;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic g_rdy(input int d);
        return (d == 0) ? req_ready_0 : req_ready_2;
    endfunction
    function automatic logic g_vld(input int d);
        return (d == 0) ? rsp_valid_0 : rsp_valid_2;
    endfunction
    function automatic logic g_err(input int d);
        return (d == 0) ? rsp_err_0 : rsp_err_2;
    endfunction
    function automatic logic [31:0] g_rdata(input int d);
        return (d == 0) ? rsp_rdata_0 : rsp_rdata_2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One full transaction; hold>0 keeps rsp_ready low and req_valid high for that many RESP cycles.
    task automatic txn(input int d, input logic st, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input int hold);
        exp_t e;
        int   n;
        @(negedge clk);
        chk("req_ready_idle", 32'(g_rdy(d)), 32'd1);
        req_valid[d] = 1'b1;
        req_is_st[d] = st;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        e.rdata = er;
        e.err   = ee;
        e.lat   = (d == 0) ? 1 : 3;
        sb.push_back(e);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (hold == 0) req_valid[d] = 1'b0;
            req_is_st[d] = 1'($urandom_range(0, 1));
            req_addr[d]  = $urandom;
            req_wdata[d] = $urandom;
        end while (!g_vld(d) && n < 40);
        if (!g_vld(d)) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
            req_valid[d] = 1'b0;
            return;
        end
        e = sb.pop_front();
        chk("latency", 32'(n), 32'(e.lat));
        chk("rsp_rdata", g_rdata(d), e.rdata);
        chk("rsp_err", 32'(g_err(d)), 32'(e.err));
        chk("req_ready_resp", 32'(g_rdy(d)), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("stall_valid", 32'(g_vld(d)), 32'd1);
            chk("stall_rdata", g_rdata(d), e.rdata);
            chk("stall_err", 32'(g_err(d)), 32'(e.err));
            chk("stall_req_ready", 32'(g_rdy(d)), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        req_valid[d] = 1'b0;
        chk("post_hs_valid", 32'(g_vld(d)), 32'd0);
        chk("post_hs_req_ready", 32'(g_rdy(d)), 32'd1);
        chk("post_hs_err", 32'(g_err(d)), 32'd0);
        chk("post_hs_rdata_kept", g_rdata(d), e.rdata);
    endtask

    task automatic chk_reset_outputs(input int d);
        chk("rst_req_ready", 32'(g_rdy(d)), 32'd1);
        chk("rst_rsp_valid", 32'(g_vld(d)), 32'd0);
        chk("rst_rsp_rdata", g_rdata(d), 32'd0);
        chk("rst_rsp_err", 32'(g_err(d)), 32'd0);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'd5,          32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'd5,          32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'd0,          32'h0BADF00D, 32'h0,        1'b0};
        vecs[3]  = '{1'b1, 32'd1023,       32'hCAFEF00D, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'd1024,       32'h0,        32'h0,        1'b1};
        vecs[5]  = '{1'b1, 32'hFFFFFFFF,   32'h55555555, 32'h0,        1'b1};
        vecs[6]  = '{1'b1, 32'd1029,       32'h66666666, 32'h0,        1'b1};
        vecs[7]  = '{1'b0, 32'd0,          32'h0,        32'h0BADF00D, 1'b0};
        vecs[8]  = '{1'b0, 32'd1023,       32'h0,        32'hCAFEF00D, 1'b0};
        vecs[9]  = '{1'b0, 32'd5,          32'h0,        32'hDEADBEEF, 1'b0};
        vecs[10] = '{1'b1, 32'd7,          32'h11112222, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 32'd7,          32'h0,        32'h11112222, 1'b0};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_is_st[d] = 1'b0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            rsp_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        rst = 1'b0;

        txn(0, 1'b1, 32'd0, 32'h12345678, 32'h0, 1'b0, 0);
        txn(0, 1'b0, 32'd0, 32'h0, 32'h12345678, 1'b0, 0);
        txn(0, 1'b0, 32'd4096, 32'h0, 32'h0, 1'b1, 0);

        for (int i = 0; i < 12; i++) begin
            txn(1, vecs[i].st, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, 0);
        end

        txn(1, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 10);

        // Store still in WAIT when reset lands must not reach the array.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_is_st[1] = 1'b1;
        req_addr[1]  = 32'd7;
        req_wdata[1] = 32'hA5A5A5A5;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs(1);
        @(negedge clk);
        rst = 1'b0;
        txn(1, 1'b0, 32'd7, 32'h0, 32'h11112222, 1'b0, 0);

        // Pending load response is discarded by reset.
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_is_st[1] = 1'b0;
        req_addr[1]  = 32'd5;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pending_rsp_valid", 32'(rsp_valid_2), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs(1);
        @(negedge clk);
        rst = 1'b0;
        txn(1, 1'b0, 32'd0, 32'h0, 32'h0BADF00D, 1'b0, 0);

`ifdef DMEM_PERF_CNT_EN
        pulse_rst();
        chk("ld_count_rst", ld_count_2, 32'd0);
        chk("st_count_rst", st_count_2, 32'd0);
        txn(1, 1'b0, 32'd5, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        txn(1, 1'b1, 32'd9, 32'h99990000, 32'h0, 1'b0, 0);
        txn(1, 1'b0, 32'd7, 32'h0, 32'h11112222, 1'b0, 0);
        txn(1, 1'b0, 32'd2000, 32'h0, 32'h0, 1'b1, 0);
        txn(1, 1'b1, 32'd10, 32'h10101010, 32'h0, 1'b0, 0);
        txn(1, 1'b0, 32'd9, 32'h0, 32'h99990000, 1'b0, 0);
        chk("ld_count", ld_count_2, 32'd3);
        chk("st_count", st_count_2, 32'd2);
        pulse_rst();
        chk("ld_count_rst2", ld_count_2, 32'd0);
        chk("st_count_rst2", st_count_2, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
